// File: rtl/event_pending_gen.sv
`default_nettype none
// ============================================================================
// event_pending_gen : sticky pending-event bits from key pulses, held-key
// auto-repeat and a level-scaled gravity timer.   Rev 1.0
// ============================================================================
`ifndef LEVEL_LEN
`define LEVEL_LEN 4
`endif
`ifndef EVENT_LEN
`define EVENT_LEN 6
`endif

module event_pending_gen #(
   parameter int FALL_BASE = 3000,
   parameter int FALL_STEP = 180,
   parameter int FALL_MIN  = 200,
   parameter int DAS       = 500,
   parameter int ARR       = 100
) (
   input  logic                  main_clk,
   input  logic                  rst_1plus,
   input  logic [4:0]            key_pulse,
   input  logic [2:0]            key_held,
   input  logic [`LEVEL_LEN-1:0] level,
   input  logic                  pause,
   input  logic [`EVENT_LEN-1:0] event_received,
   output logic [`EVENT_LEN-1:0] event_out,
   output logic [7:0]            drop_cnt
);

   localparam logic [15:0] c_fall_base = 16'(FALL_BASE);
   localparam logic [15:0] c_fall_step = 16'(FALL_STEP);
   localparam logic [15:0] c_fall_min  = 16'(FALL_MIN);
   localparam logic [15:0] c_das_last  = 16'(DAS - 1);
   localparam logic [15:0] c_arr_last  = 16'(ARR - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DELAY  = 2'd1,
      S_REPEAT = 2'd2
   } rpt_state_t;

   logic [`EVENT_LEN-1:0] r_event;
   logic [7:0]            r_drop;
   logic [15:0]           r_grav_cnt;
   logic [2:0]            r_held_prev;
   logic [2:0]            w_fire;
   logic [15:0]           w_step_total;
   logic [15:0]           w_period;
   logic                  w_expire;
   logic                  w_down_raise;
   logic [`EVENT_LEN-1:0] w_raise;
   logic                  w_coalesce;

   // Period is clamped before subtracting so the 16-bit difference never wraps.
   assign w_step_total = 16'(level) * c_fall_step;
   assign w_period     = ((w_step_total >= c_fall_base) ||
                          ((c_fall_base - w_step_total) < c_fall_min)) ?
                         c_fall_min : (c_fall_base - w_step_total);
   assign w_expire     = ~pause & (r_grav_cnt >= (w_period - 16'd1));
   assign w_down_raise = key_pulse[1] | w_fire[0];

   // A DOWN move already dropped the piece, so it swallows a coincident expiry.
   assign w_raise = {w_expire & ~w_down_raise,
                     key_pulse[4],
                     key_pulse[3] | w_fire[2],
                     key_pulse[2] | w_fire[1],
                     w_down_raise,
                     key_pulse[0]};

   assign w_coalesce = |(w_raise & r_event & ~event_received);

   always_ff @(posedge main_clk or posedge rst_1plus) begin
      if (rst_1plus) begin
         r_grav_cnt <= 16'd0;
      end else if (w_down_raise) begin
         r_grav_cnt <= 16'd0;
      end else if (pause) begin
         r_grav_cnt <= r_grav_cnt;
      end else if (w_expire) begin
         r_grav_cnt <= 16'd0;
      end else begin
         r_grav_cnt <= r_grav_cnt + 16'd1;
      end
   end

   always_ff @(posedge main_clk or posedge rst_1plus) begin
      if (rst_1plus) begin
         r_held_prev <= 3'b000;
      end else begin
         r_held_prev <= key_held;
      end
   end

   // Held-key index 0/1/2 = DOWN/RIGHT/LEFT.
   for (genvar k = 0; k < 3; k++) begin : g_rpt
      rpt_state_t  r_state;
      rpt_state_t  w_state_nxt;
      logic [15:0] r_cnt;
      logic [15:0] w_cnt_nxt;
      logic        w_fire_k;

      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
         w_fire_k    = 1'b0;
         if (!key_held[k]) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 16'd0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (!r_held_prev[k]) begin
                     w_state_nxt = S_DELAY;
                     w_cnt_nxt   = 16'd0;
                  end
               end
               S_DELAY: begin
                  if (!pause) begin
                     if (r_cnt >= c_das_last) begin
                        w_fire_k    = 1'b1;
                        w_cnt_nxt   = 16'd0;
                        w_state_nxt = S_REPEAT;
                     end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                     end
                  end
               end
               S_REPEAT: begin
                  if (!pause) begin
                     if (r_cnt >= c_arr_last) begin
                        w_fire_k  = 1'b1;
                        w_cnt_nxt = 16'd0;
                     end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                     end
                  end
               end
               default: begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = 16'd0;
               end
            endcase
         end
      end

      always_ff @(posedge main_clk or posedge rst_1plus) begin
         if (rst_1plus) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
         end
      end

      assign w_fire[k] = w_fire_k;
   end

   always_ff @(posedge main_clk or posedge rst_1plus) begin
      if (rst_1plus) begin
         r_event <= '0;
         r_drop  <= 8'd0;
      end else begin
         r_event <= w_raise | (r_event & ~event_received);
         if (w_coalesce && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
         end
      end
   end

   assign event_out = r_event;
   assign drop_cnt  = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_event_pending_gen.sv
`default_nettype none
// ============================================================================
// tb_event_pending_gen : directed self-checking bench for event_pending_gen.
// Rev 1.0
// ============================================================================
module tb_event_pending_gen;

   logic       main_clk = 1'b0;
   logic       rst_1plus;
   logic [4:0] key_pulse;
   logic [2:0] key_held;
   logic [3:0] level;
   logic       pause;
   logic [5:0] event_received;
   logic [5:0] ev;
   logic [7:0] drop;

   logic [4:0] k2_pulse = 5'b0;
   logic [2:0] k2_held  = 3'b0;
   logic [3:0] lvl2     = 4'd15;
   logic [5:0] recv2    = 6'b100000;
   logic [5:0] ev2;
   logic [7:0] drop2;

   int checks   = 0;
   int failures = 0;

   always #5 main_clk = ~main_clk;

   event_pending_gen u_dut (
      .main_clk      (main_clk),
      .rst_1plus     (rst_1plus),
      .key_pulse     (key_pulse),
      .key_held      (key_held),
      .level         (level),
      .pause         (pause),
      .event_received(event_received),
      .event_out     (ev),
      .drop_cnt      (drop)
   );

   event_pending_gen #(.FALL_STEP(200)) u_dut_floor (
      .main_clk      (main_clk),
      .rst_1plus     (rst_1plus),
      .key_pulse     (k2_pulse),
      .key_held      (k2_held),
      .level         (lvl2),
      .pause         (pause),
      .event_received(recv2),
      .event_out     (ev2),
      .drop_cnt      (drop2)
   );

   task automatic tick();
      @(posedge main_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Ticks until the selected DUT shows FALL, bounded by max_cycles.
   task automatic wait_fall(input int max_cycles, input bit sel, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(sel ? ev2[5] : ev[5]) && (n < max_cycles));
   endtask

   initial begin : main
      int n;
      int falls;
      int nr;
      int rtimes[4];

      rst_1plus      = 1'b1;
      key_pulse      = 5'b0;
      key_held       = 3'b0;
      level          = 4'd0;
      pause          = 1'b0;
      event_received = 6'b100000;
      repeat (3) tick();
      check("reset_event_out", 32'(ev), 32'd0);
      check("reset_drop_cnt", 32'(drop), 32'd0);
      rst_1plus = 1'b0;
      tick();

      // Single SPACE pulse, held until acknowledged
      key_pulse = 5'b10000;
      tick();
      key_pulse = 5'b0;
      check("space_pending", 32'(ev[4:0]), 32'h10);
      repeat (3) tick();
      check("space_held", 32'(ev[4:0]), 32'h10);
      event_received = 6'b110000;
      tick();
      event_received = 6'b100000;
      check("space_ack", 32'(ev[4:0]), 32'h0);

      // LEFT twice without ack -> coalesced
      key_pulse = 5'b01000;
      tick();
      key_pulse = 5'b0;
      repeat (4) tick();
      key_pulse = 5'b01000;
      tick();
      key_pulse = 5'b0;
      check("left_coalesce_bit", 32'(ev[3]), 32'd1);
      check("left_coalesce_drop", 32'(drop), 32'd1);
      key_pulse      = 5'b01000;
      event_received = 6'b101000;
      tick();
      key_pulse      = 5'b0;
      event_received = 6'b100000;
      check("raise_and_ack_bit", 32'(ev[3]), 32'd1);
      check("raise_and_ack_drop", 32'(drop), 32'd1);
      event_received = 6'b101000;
      tick();
      event_received = 6'b100000;
      check("left_ack", 32'(ev[3]), 32'd0);

      // Gravity periods
      wait_fall(4000, 1'b0, n);
      wait_fall(4000, 1'b0, n);
      check("fall_period_lvl0", 32'(n), 32'd3000);
      level = 4'd15;
      wait_fall(4000, 1'b0, n);
      check("fall_period_lvl15", 32'(n), 32'd300);
      wait_fall(4000, 1'b1, n);
      wait_fall(4000, 1'b1, n);
      check("fall_period_floor", 32'(n), 32'd200);

      // DOWN pulse at count 2500 restarts gravity
      wait_fall(4000, 1'b0, n);
      level = 4'd0;
      repeat (2500) tick();
      key_pulse = 5'b00010;
      tick();
      key_pulse = 5'b0;
      check("down_pending", 32'(ev[1]), 32'd1);
      wait_fall(4000, 1'b0, n);
      check("fall_after_down", 32'(n), 32'd3000);
      event_received = 6'b100010;
      tick();
      event_received = 6'b100000;

      // Pause freezes gravity for 1000 cycles
      wait_fall(4000, 1'b0, n);
      repeat (1000) tick();
      pause = 1'b1;
      falls = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (ev[5]) falls++;
      end
      pause = 1'b0;
      check("no_fall_in_pause", 32'(falls), 32'd0);
      wait_fall(4000, 1'b0, n);
      check("fall_after_pause", 32'(n), 32'd2000);

      // RIGHT held for 800 cycles
      event_received = 6'b100100;
      key_held = 3'b010;
      nr = 0;
      for (int t = 0; t < 800; t++) begin
         tick();
         if (ev[2]) begin
            if (nr < 4) rtimes[nr] = t;
            nr++;
         end
      end
      key_held = 3'b000;
      for (int t = 0; t < 300; t++) begin
         tick();
         if (ev[2]) nr++;
      end
      check("right_repeat_count", 32'(nr), 32'd3);
      check("right_repeat_1st", 32'(rtimes[0]), 32'd500);
      check("right_repeat_2nd", 32'(rtimes[1]), 32'd600);
      check("right_repeat_3rd", 32'(rtimes[2]), 32'd700);
      event_received = 6'b100000;

      // Asynchronous reset while LEFT is auto-repeating
      key_held = 3'b100;
      repeat (520) tick();
      key_pulse = 5'b00001;
      tick();
      key_pulse = 5'b0;
      check("up_before_reset", 32'(ev[0]), 32'd1);
      rst_1plus = 1'b1;
      #2;
      check("async_reset_event_out", 32'(ev), 32'd0);
      check("async_reset_drop_cnt", 32'(drop), 32'd0);
      key_held = 3'b000;
      repeat (2) tick();
      rst_1plus = 1'b0;
      repeat (5) tick();
      check("post_reset_quiet", 32'(ev), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/event_pending_gen.md
Name: event_pending_gen

Overview:
- Producer end of the event_out / event_received handshake consumed by the game FSM.
- Turns one-cycle key pulses from the PS/2 key decoder, held-key levels, and a level-scaled gravity timer into sticky pending-event bits.
- Each bit stays asserted until the game FSM acknowledges it.
- Sits between the keyboard decoder and the game logic, entirely in the main_clk domain.

Parameters:
- FALL_BASE, 3000, gravity period in main_clk cycles at level 0.
- FALL_STEP, 180, period reduction per level.
- FALL_MIN, 200, floor on the gravity period.
- DAS, 500, held-key cycles before auto-repeat starts.
- ARR, 100, auto-repeat period in cycles once repeating.

Ports:
- main_clk  in  1  system tick, about 3 kHz.
- rst_1plus  in  1  asynchronous, active-high reset.
- key_pulse  in  5  one-cycle press pulses; bit 0 UP, 1 DOWN, 2 RIGHT, 3 LEFT, 4 SPACE.
- key_held  in  3  held levels; bit 0 DOWN, 1 RIGHT, 2 LEFT.
- level  in  `LEVEL_LEN (4)  current game level, 0..15.
- pause  in  1  high freezes gravity and auto-repeat.
- event_received  in  `EVENT_LEN (6)  acknowledge bits from the consumer.
- event_out  out  `EVENT_LEN (6)  pending events; bit 0 KEY_UP, 1 KEY_DOWN, 2 KEY_RIGHT, 3 KEY_LEFT, 4 KEY_SPACE, 5 FALL.
- drop_cnt  out  8  saturating count of coalesced (lost) events.

Behaviour:
- Reset (asynchronous, rst_1plus high), all of the following:
  - event_out=0, drop_cnt=0.
  - Gravity counter = 0.
  - Repeat counters = 0; repeat FSMs in IDLE.
- Raise sources, per bit, computed each cycle:
  - Bits 0..4: raise[i] = key_pulse[i], or an auto-repeat fire on DOWN/RIGHT/LEFT.
  - Bit 5: raise[5] = gravity expiry.
- Pending-bit update, registered, 1-cycle latency:
  - event_out[i] <= raise[i] | (event_out[i] & ~event_received[i]).
  - Raise and acknowledge in the same cycle: the bit stays 1, so the new event remains pending.
  - Acknowledging a bit that is 0 has no effect.
- Coalescing:
  - A raise while event_out[i]=1 and event_received[i]=0 is merged into the pending bit.
  - Each such merge increments drop_cnt by 1, saturating at 255.
  - When several bits coalesce in the same cycle, drop_cnt increments by 1 only.
- Gravity timer:
  - period = max(FALL_BASE − level*FALL_STEP, FALL_MIN); use 16-bit arithmetic, no underflow.
  - Counter increments every unpaused cycle. When it reaches period−1, it fires raise[5] and reloads to 0.
  - A level change takes effect at the next comparison. If the counter is already ≥ the new period−1, it fires on the next cycle.
  - Any KEY_DOWN raise (pulse or repeat) reloads the counter to 0, so gravity does not double-drop.
  - pause=1: counter holds, no FALL raise. Pending bits still clear on acknowledge.
- Auto-repeat, one FSM per held key (DOWN, RIGHT, LEFT):
  - IDLE → DELAY on key_held rising; count clears. The press itself is signalled by key_pulse, not by the FSM.
  - DELAY: count up. At DAS−1, fire a repeat raise, clear the count, go to REPEAT.
  - REPEAT: count up. At ARR−1, fire a repeat raise and clear the count.
  - key_held low in any state → IDLE, count cleared.
  - pause=1 → counts hold.
- Reset mid-operation returns everything to reset values immediately. No event is raised during reset.
- Outputs are registered only; no combinational path from inputs to event_out.

Test Plan:
- Reset, then key_pulse[4] for 1 cycle, event_received=0:
  - event_out=6'b010000 from the next cycle and held.
  - Acknowledge bit 4 for 1 cycle → event_out=0 the cycle after.
- level=0, pause=0, no keys:
  - FALL bit rises exactly every 3000 cycles.
  - level=15 → period 300. level=15 with FALL_STEP=200 → floored to 200.
- KEY_LEFT pulse twice, 5 cycles apart, without acknowledge:
  - event_out[3]=1 and drop_cnt=1.
  - Pulse and acknowledge in the same cycle → bit stays 1.
- key_held[1] high for 800 cycles:
  - RIGHT repeat raises at cycle 500, 600 and 700 after the rising edge.
  - Release → no further raises.
- KEY_DOWN pulse at gravity count 2500, level 0:
  - Next FALL arrives 3000 cycles after the pulse, not 500.
- pause=1 for 1000 cycles mid-count:
  - No FALL raised; expiry is delayed by exactly 1000 cycles.
  - Assert rst_1plus mid-repeat → all outputs 0 asynchronously.
